img_window_ctrl: RTL and testbench

- Operation controller for the 8x8x32 image buffer held in the 4096x8 single-port SRAM.
- Accepts op-mode commands, sequences the 2048-byte image load into SRAM, and keeps the 2x2 display-window origin and the channel depth.
- Streams display-window pixels from SRAM to the output port.
- Owns the only SRAM port. Downstream filter blocks get pixel data through the o_out_* stream.

---
 rtl/img_window_ctrl.sv | 178 +++++++++++++++++
 tb/tb_img_window_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/img_window_ctrl.sv
// Operation controller for the 8x8x32 image held in a 4096x8 single-port SRAM.
// Sequences the 2048-byte image load, keeps the 2x2 display-window origin and
// channel depth, and streams the display window out of SRAM one pixel a cycle.
module img_window_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 14
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_op_valid,
  input  logic [3:0]        i_op_mode,
  output logic              o_op_ready,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_sram_cen,
  output logic              o_sram_wen,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_d,
  input  logic [DATA_W-1:0] i_sram_q,
  output logic              o_out_valid,
  output logic [OUT_W-1:0]  o_out_data
);

  localparam logic [2:0] S_RST   = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_DISP  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  // Origin may only reach 6 so the 2x2 window stays inside the 8x8 plane.
  localparam logic [2:0] ORIGIN_MAX = 3'd6;
  localparam logic [10:0] LOAD_LAST = 11'd2047;

  logic [2:0]  state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [2:0]  x_q, x_d;
  logic [2:0]  y_q, y_d;
  logic [5:0]  depth_q, depth_d;

  logic              rd_q;
  logic              out_valid_q;
  logic [OUT_W-1:0]  out_data_q;

  logic        load_wr;
  logic        disp_rd;
  logic [10:0] disp_last;
  logic [4:0]  elem_ch;
  logic [1:0]  elem_slot;
  logic [2:0]  elem_row;
  logic [2:0]  elem_col;
  logic [11:0] disp_addr;

  assign load_wr   = (state_q == S_LOAD) && i_in_valid;
  assign disp_rd   = (state_q == S_DISP);
  // Last element index of a display pass: depth*4 - 1.
  assign disp_last = {3'b000, depth_q, 2'b00} - 11'd1;

  // Element k = 4*channel + slot; slots walk (x,y),(x+1,y),(x,y+1),(x+1,y+1).
  assign elem_ch   = cnt_q[6:2];
  assign elem_slot = cnt_q[1:0];
  assign elem_col  = x_q + {2'b00, elem_slot[0]};
  assign elem_row  = y_q + {2'b00, elem_slot[1]};
  assign disp_addr = {1'b0, elem_ch, elem_row, elem_col};

  // Next-state logic: op decode, load/display counters, window origin and depth.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    depth_d = depth_q;
    case (state_q)
      S_RST:   state_d = S_READY;
      S_READY: state_d = S_WAIT;
      S_WAIT: begin
        if (i_op_valid) begin
          state_d = S_READY;
          case (i_op_mode)
            4'd0: begin
              state_d = S_LOAD;
              cnt_d   = '0;
            end
            4'd1: if (x_q < ORIGIN_MAX) x_d = x_q + 3'd1;
            4'd2: if (x_q != 3'd0)      x_d = x_q - 3'd1;
            4'd3: if (y_q != 3'd0)      y_d = y_q - 3'd1;
            4'd4: if (y_q < ORIGIN_MAX) y_d = y_q + 3'd1;
            4'd5: begin
              if (depth_q == 6'd32)      depth_d = 6'd16;
              else if (depth_q == 6'd16) depth_d = 6'd8;
            end
            4'd6: begin
              if (depth_q == 6'd8)       depth_d = 6'd16;
              else if (depth_q == 6'd16) depth_d = 6'd32;
            end
            4'd7: begin
              state_d = S_DISP;
              cnt_d   = '0;
            end
            default: state_d = S_READY;
          endcase
        end
      end
      S_LOAD: begin
        if (i_in_valid) begin
          // The counter wraps to zero on the final write, leaving it cleared.
          cnt_d = cnt_q + 11'd1;
          if (cnt_q == LOAD_LAST) state_d = S_READY;
        end
      end
      S_DISP: begin
        if (cnt_q == disp_last) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      S_DRAIN: begin
        // Two cycles so the last SRAM read reaches the output register.
        if (cnt_q[0]) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      default: state_d = S_RST;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    if (!i_rst_n) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      depth_q <= 6'd32;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      depth_q <= depth_d;
    end
  end

  // Read pipeline: SRAM data arrives one cycle after the read, then is registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      rd_q        <= disp_rd;
      out_valid_q <= rd_q;
      out_data_q  <= rd_q ? OUT_W'(i_sram_q) : '0;
    end
  end

  assign o_op_ready  = (state_q == S_READY);
  assign o_in_ready  = (state_q == S_LOAD);
  assign o_sram_cen  = ~(load_wr | disp_rd);
  assign o_sram_wen  = ~load_wr;
  assign o_sram_addr = load_wr ? ADDR_W'(cnt_q)
                     : (disp_rd ? ADDR_W'(disp_addr) : '0);
  assign o_sram_d    = load_wr ? i_in_data : '0;
  assign o_out_valid = out_valid_q;
  assign o_out_data  = out_data_q;

endmodule

// File: tb/tb_img_window_ctrl.sv
// Self-checking bench for img_window_ctrl: behavioural SRAM, a table of op
// records with hand-computed window state, and directed load/reset sequences.
module tb_img_window_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [3:0]  op_mode;
  logic        op_ready;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        sram_cen;
  logic        sram_wen;
  logic [11:0] sram_addr;
  logic [7:0]  sram_d;
  logic [7:0]  sram_q;
  logic        out_valid;
  logic [13:0] out_data;

  always #5 clk = ~clk;

  img_window_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_op_valid  (op_valid),
    .i_op_mode   (op_mode),
    .o_op_ready  (op_ready),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (in_ready),
    .o_sram_cen  (sram_cen),
    .o_sram_wen  (sram_wen),
    .o_sram_addr (sram_addr),
    .o_sram_d    (sram_d),
    .i_sram_q    (sram_q),
    .o_out_valid (out_valid),
    .o_out_data  (out_data)
  );

  // Behavioural 4096x8 single-port SRAM, read data one cycle after the address.
  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) mem[sram_addr] <= sram_d;
      else           sram_q <= mem[sram_addr];
    end
  end

  typedef struct {
    logic [3:0] mode;
    int         ex;
    int         ey;
    int         ed;
  } op_t;

  op_t ops[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cap[0:127];
  int  cap_n;
  int  exp_a[8] = '{0, 1, 8, 9, 64, 65, 72, 73};
  int  exp_b[8] = '{54, 55, 62, 63, 118, 119, 126, 127};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] m, input int x, input int y, input int d);
    op_t o;
    o.mode = m; o.ex = x; o.ey = y; o.ed = d;
    ops.push_back(o);
  endtask

  // Starts at the negedge of a READY cycle; returns just after the acceptance edge.
  task automatic do_op(input logic [3:0] m, input int idle);
    repeat (idle + 1) @(negedge clk);
    op_valid = 1'b1;
    op_mode  = m;
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  // Non-display op: READY pulse in cycle 0, no SRAM access, no output.
  task automatic check_simple(input logic [3:0] m);
    @(negedge clk);
    check($sformatf("op%0d_ready", m), op_ready, 1);
    check($sformatf("op%0d_cen", m), sram_cen, 1);
    check($sformatf("op%0d_outv", m), out_valid, 0);
  endtask

  function automatic int elem_addr(input int k, input int ex, input int ey);
    return (k / 4) * 64 + (ey + (k % 4) / 2) * 8 + ex + (k % 2);
  endfunction

  // Display op: checks read addresses, the output stream and the READY cycle N+2.
  task automatic check_display(input int ex, input int ey, input int ed);
    int n;
    n = ed * 4;
    cap_n = 0;
    for (int j = 0; j <= n + 2; j++) begin
      @(negedge clk);
      if (j < n) begin
        check($sformatf("disp_cen k%0d", j), sram_cen, 0);
        check($sformatf("disp_wen k%0d", j), sram_wen, 1);
        check($sformatf("disp_addr k%0d", j), sram_addr, elem_addr(j, ex, ey));
      end else begin
        check($sformatf("disp_idle_cen c%0d", j), sram_cen, 1);
      end
      if (j >= 2 && j < n + 2) begin
        check($sformatf("outv c%0d", j), out_valid, 1);
        check($sformatf("outd c%0d", j), out_data, elem_addr(j - 2, ex, ey) % 256);
      end else begin
        check($sformatf("outv_lo c%0d", j), out_valid, 0);
        check($sformatf("outd_lo c%0d", j), out_data, 0);
      end
      check($sformatf("disp_ready c%0d", j), op_ready, (j == n + 2) ? 1 : 0);
      if (out_valid === 1'b1 && cap_n < 128) begin
        cap[cap_n] = int'(out_data);
        cap_n++;
      end
    end
    check("disp_count", cap_n, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, op_ready, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_outv"}, out_valid, 0);
    check({tag, "_outd"}, out_data, 0);
    check({tag, "_cen"}, sram_cen, 1);
    check({tag, "_wen"}, sram_wen, 1);
    check({tag, "_addr"}, sram_addr, 0);
    check({tag, "_d"}, sram_d, 0);
  endtask

  initial begin
    int a;
    int gap;
    bit wr;

    // Hand-computed op sequence: {mode, expected x, y, depth after the op}.
    add(7, 0, 0, 32);
    add(1, 1, 0, 32); add(1, 2, 0, 32); add(1, 3, 0, 32); add(1, 4, 0, 32);
    add(1, 5, 0, 32); add(1, 6, 0, 32); add(1, 6, 0, 32);
    add(4, 6, 1, 32); add(4, 6, 2, 32); add(4, 6, 3, 32); add(4, 6, 4, 32);
    add(4, 6, 5, 32); add(4, 6, 6, 32); add(4, 6, 6, 32);
    add(7, 6, 6, 32);
    add(5, 6, 6, 16); add(5, 6, 6, 8); add(5, 6, 6, 8);
    add(7, 6, 6, 8);
    add(6, 6, 6, 16);
    add(7, 6, 6, 16);
    add(2, 5, 6, 16); add(2, 4, 6, 16); add(2, 3, 6, 16);
    add(2, 2, 6, 16); add(2, 1, 6, 16); add(2, 0, 6, 16);
    add(3, 0, 5, 16); add(3, 0, 4, 16); add(3, 0, 3, 16);
    add(3, 0, 2, 16); add(3, 0, 1, 16); add(3, 0, 0, 16);
    add(2, 0, 0, 16); add(3, 0, 0, 16);
    add(7, 0, 0, 16);
    add(12, 0, 0, 16);
    add(7, 0, 0, 16);

    rst_n    = 1'b0;
    op_valid = 1'b0;
    op_mode  = 4'd0;
    in_valid = 1'b0;
    in_data  = 8'd0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("first_ready", op_ready, 1);

    // Image load with a three-cycle gap before byte 100.
    do_op(4'd0, 0);
    a = 0;
    gap = 0;
    while (a < 2048) begin
      wr = !(a == 100 && gap < 3);
      if (!wr) gap++;
      in_valid = wr;
      in_data  = 8'(a % 256);
      @(negedge clk);
      if (a % 97 == 0 || a >= 2046 || !wr) begin
        check($sformatf("ld_in_ready a%0d", a), in_ready, 1);
        check($sformatf("ld_cen a%0d", a), sram_cen, wr ? 0 : 1);
        check($sformatf("ld_wen a%0d", a), sram_wen, wr ? 0 : 1);
        if (wr) begin
          check($sformatf("ld_addr a%0d", a), sram_addr, a);
          check($sformatf("ld_d a%0d", a), sram_d, a % 256);
        end
      end
      @(posedge clk);
      #1;
      if (wr) a++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("ld_done_ready", op_ready, 1);
    check("ld_done_in_ready", in_ready, 0);

    // Table-driven op sequence.
    for (int i = 0; i < ops.size(); i++) begin
      do_op(ops[i].mode, i % 3);
      if (ops[i].mode == 4'd7) check_display(ops[i].ex, ops[i].ey, ops[i].ed);
      else                     check_simple(ops[i].mode);
      if (i == 0) begin
        for (int j = 0; j < 8; j++) check($sformatf("first8 e%0d", j), cap[j], exp_a[j]);
        check("elem16_ch4", cap[16], 0);
      end
      if (i == 15) begin
        for (int j = 0; j < 8; j++) check($sformatf("sat66 e%0d", j), cap[j], exp_b[j]);
      end
      if (i == 36) begin
        for (int j = 0; j < 4; j++) check($sformatf("org00 e%0d", j), cap[j], exp_a[j]);
      end
    end

    // Move the origin, then reset in the middle of a display at k = 20.
    do_op(4'd1, 0);
    check_simple(4'd1);
    do_op(4'd7, 0);
    for (int j = 0; j <= 20; j++) @(negedge clk);
    check("mid_outv_before", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", op_ready, 1);
    do_op(4'd7, 1);
    check_display(0, 0, 32);
    for (int j = 0; j < 4; j++) check($sformatf("postrst e%0d", j), cap[j], exp_a[j]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
